mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator (requester) side of the data-memory port (memOp/addrB/dinB -> doutB/bValid) of the word-wide unified memory model.
- Sits in the MEM stage of the core. It accepts one load/store request at a time from the pipeline and drives the memory's word-only data port.
- Performs byte-lane extraction and sign/zero extension for loads. Builds sub-word stores by read-modify-write.
- Reports misalignment, illegal size codes and response timeout as errors.

Parameters:
- MEM_DISABLE, 2'b00, memOp code: no access.
- MEM_READ_SEXT, 2'b01, memOp code: read (used for LB/LH/LW).
- MEM_READ_ZEXT, 2'b10, memOp code: read (used for LBU/LHU and RMW reads).
- MEM_WRITE, 2'b11, memOp code: full-word write.
- TIMEOUT, 16, maximum cycles spent in WAIT_RD without bValid before an error response; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  pipeline request strobe.
- req_ready  out  1  high only in IDLE; the request is accepted when req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle completion pulse; there is no backpressure.
- rsp_rdata  out  32  load result, valid with rsp_valid; 0 for stores and errors.
- rsp_err  out  1  error flag, valid with rsp_valid.
- memOp  out  2  to memory; registered.
- addrB  out  32  to memory; word address {addr[31:2],2'b00}; registered.
- dinB  out  32  to memory write data; registered; 0 except during a write.
- doutB  in  32  from memory; read data.
- bValid  in  1  from memory; read data valid.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - memOp = MEM_DISABLE, addrB = 0, dinB = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Timeout counter = 0; captured request registers = 0.
  - Asserting reset mid-operation aborts immediately. No write may be issued afterwards.
- Memory timing contract: the memory samples memOp/addrB/dinB on edge N and presents doutB/bValid registered after edge N. bValid is therefore seen one cycle after the read cycle.
- Every memOp other than MEM_DISABLE is held for exactly one cycle. addrB is held stable from the issue cycle until the next request is accepted.
- States: IDLE, RD, WAIT_RD, WR, RSP.
- IDLE: on accept, capture we/funct3/addr/wdata, then check the request:
  - Illegal funct3 is an error: loads 011/110/111; stores with funct3 >= 011.
  - Misalignment is an error: H with addr[0] != 0; W with addr[1:0] != 0.
  - On error: go to RSP with err = 1 and issue no memory access.
  - SW: go to WR with dinB = wdata.
  - Otherwise (any load, SB, SH): go to RD.
- RD: memOp = MEM_READ_SEXT for LB/LH/LW, MEM_READ_ZEXT for LBU/LHU/SB/SH. Next state: WAIT_RD with counter cleared.
- WAIT_RD: memOp = MEM_DISABLE.
  - On bValid, load: extract the lane (little-endian, byte n = bits [8n+7:8n], n = addr[1:0]; half at addr[1] selects [31:16] or [15:0]), then sign- or zero-extend per funct3. Go to RSP.
  - On bValid, SB/SH: merge wdata[7:0] or wdata[15:0] into the selected lane of doutB, load dinB with the result, and go to WR.
  - Without bValid: increment the counter. When the counter reaches TIMEOUT, go to RSP with err = 1 and rdata = 0.
- WR: memOp = MEM_WRITE, dinB as set. Next state: RSP.
- RSP: rsp_valid = 1 for one cycle with rdata/err. memOp = MEM_DISABLE and dinB = 0 from this cycle. Next state: IDLE.
- bValid arriving outside WAIT_RD (late or spurious) is ignored.
- Latency, counted from the cycle the request is accepted (cycle 0) to the rsp_valid cycle:
  - Load: 3 cycles.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Error: 1 cycle.
- Throughput: a new request can be accepted in the cycle after RSP.

Test Plan:
- LW addr 0x10, doutB 0xDEADBEEF -> memOp 01 in cycle 1 with addrB 0x10; rsp_valid in cycle 3 with rdata 0xDEADBEEF, err 0.
- LB addr 0x13, doutB 0x80112233 -> rdata 0xFFFFFF80. Repeat as LBU -> 0x00000080. As LHU addr 0x12 -> 0x00008011.
- SB addr 0x21, wdata 0x000000AB, read returns 0x11223344 -> cycle 1 memOp 10; cycle 3 memOp 11 with addrB 0x20 and dinB 0x1122AB44; rsp_valid in cycle 4.
- SW addr 0x4 wdata 0xCAFEF00D -> memOp 11 with dinB 0xCAFEF00D in cycle 1; rsp_valid in cycle 2.
- LH addr 0x05, and a load with funct3 011 -> rsp_err 1 in cycle 1; memOp stays 00 throughout.
- bValid held 0 after an LW -> rsp_err 1 after 16 WAIT_RD cycles. Separately, reset pulled low during WAIT_RD of an SH -> memOp 00 immediately, no write after release, req_ready 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-wide data port: byte/half loads with extension,
// sub-word stores by read-modify-write, and error reporting for bad requests or a silent memory.
module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  memOp,
    output logic [31:0] addrB,
    output logic [31:0] dinB,
    input  logic [31:0] doutB,
    input  logic        bValid
);

    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD      = 3'd1;
    localparam logic [2:0] WAIT_RD = 3'd2;
    localparam logic [2:0] WR      = 3'd3;
    localparam logic [2:0] RSP     = 3'd4;

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [2:0]    state;
    logic          capWe;
    logic [2:0]    capFunct3;
    logic [1:0]    capLane;
    logic [15:0]   capWdata;
    logic [CW-1:0] waitCount;

    logic          illegalSize;
    logic          misaligned;
    logic          reqErr;
    logic [7:0]    byteSel;
    logic [15:0]   halfSel;
    logic [31:0]   loadData;
    logic [31:0]   mergedWord;

    assign req_ready = (state == IDLE);

    always_comb begin
        illegalSize = req_we ? (req_funct3 >= 3'b011)
                             : (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111);
        misaligned  = 1'b0;
        if (req_funct3[1:0] == 2'b01)
            misaligned = req_addr[0];
        else if (req_funct3[1:0] == 2'b10)
            misaligned = (req_addr[1:0] != 2'b00);
        reqErr = illegalSize || misaligned;
    end

    // Lane extraction for loads and lane insertion for the write-back half of RMW stores.
    always_comb begin
        byteSel    = 8'h00;
        case (capLane)
            2'd0: byteSel = doutB[7:0];
            2'd1: byteSel = doutB[15:8];
            2'd2: byteSel = doutB[23:16];
            default: byteSel = doutB[31:24];
        endcase
        halfSel    = capLane[1] ? doutB[31:16] : doutB[15:0];

        loadData   = doutB;
        case (capFunct3)
            3'b000: loadData = {{24{byteSel[7]}}, byteSel};
            3'b001: loadData = {{16{halfSel[15]}}, halfSel};
            3'b100: loadData = {24'h000000, byteSel};
            3'b101: loadData = {16'h0000, halfSel};
            default: loadData = doutB;
        endcase

        mergedWord = doutB;
        if (capFunct3[1:0] == 2'b00) begin
            case (capLane)
                2'd0: mergedWord[7:0]   = capWdata[7:0];
                2'd1: mergedWord[15:8]  = capWdata[7:0];
                2'd2: mergedWord[23:16] = capWdata[7:0];
                default: mergedWord[31:24] = capWdata[7:0];
            endcase
        end else if (capLane[1]) begin
            mergedWord[31:16] = capWdata;
        end else begin
            mergedWord[15:0] = capWdata;
        end
    end

    // Memory-facing outputs are registered, so each is loaded on the edge entering its state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            capWe     <= 1'b0;
            capFunct3 <= 3'b000;
            capLane   <= 2'b00;
            capWdata  <= 16'h0000;
            waitCount <= '0;
            memOp     <= MEM_DISABLE;
            addrB     <= 32'h0;
            dinB      <= 32'h0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        capWe     <= req_we;
                        capFunct3 <= req_funct3;
                        capLane   <= req_addr[1:0];
                        capWdata  <= req_wdata[15:0];
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        if (reqErr) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            state     <= RSP;
                        end else if (req_we && req_funct3 == 3'b010) begin
                            memOp <= MEM_WRITE;
                            addrB <= {req_addr[31:2], 2'b00};
                            dinB  <= req_wdata;
                            state <= WR;
                        end else begin
                            memOp <= (!req_we && !req_funct3[2]) ? MEM_READ_SEXT : MEM_READ_ZEXT;
                            addrB <= {req_addr[31:2], 2'b00};
                            state <= RD;
                        end
                    end
                end
                RD: begin
                    memOp     <= MEM_DISABLE;
                    waitCount <= '0;
                    state     <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (bValid) begin
                        if (capWe) begin
                            memOp <= MEM_WRITE;
                            dinB  <= mergedWord;
                            state <= WR;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= loadData;
                            state     <= RSP;
                        end
                    end else if (waitCount == CW'(TIMEOUT - 1)) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 32'h0;
                        state     <= RSP;
                    end else begin
                        waitCount <= waitCount + 1'b1;
                    end
                end
                WR: begin
                    memOp     <= MEM_DISABLE;
                    dinB      <= 32'h0;
                    rsp_valid <= 1'b1;
                    rsp_rdata <= 32'h0;
                    state     <= RSP;
                end
                RSP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a one-cycle-latency word memory model plus
// a vector table for single requests and hand-written timeout/reset/spurious-valid sequences.
module tb_mem_access_unit;

    typedef struct {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] memData;
        logic [31:0] expRdata;
        logic        expErr;
        logic [1:0]  expOp;
        int          expLat;
        logic [31:0] expWrData;
    } Vector;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  memOp;
    logic [31:0] addrB;
    logic [31:0] dinB;
    logic [31:0] doutB;
    logic        bValid;

    logic [31:0] memWord = 32'h0;
    logic        stallMem = 1'b0;
    logic        forceValid = 1'b0;
    int          readCount = 0;
    int          writeCount = 0;
    logic [31:0] lastWrAddr = 32'h0;
    logic [31:0] lastWrData = 32'h0;

    int checkCount = 0;
    int errorCount = 0;

    Vector vecs[18];

    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .memOp      (memOp),
        .addrB      (addrB),
        .dinB       (dinB),
        .doutB      (doutB),
        .bValid     (bValid)
    );

    always #5 clk = ~clk;

    // Memory model: samples the port on an edge and answers reads one cycle later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            bValid <= 1'b0;
            doutB  <= 32'h0;
        end else begin
            bValid <= ((memOp == 2'b01 || memOp == 2'b10) && !stallMem) || forceValid;
            doutB  <= memWord;
            if (memOp == 2'b01 || memOp == 2'b10)
                readCount <= readCount + 1;
            if (memOp == 2'b11) begin
                writeCount <= writeCount + 1;
                lastWrAddr <= addrB;
                lastWrData <= dinB;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request, follows it to its response and checks timing, data and memory traffic.
    task automatic applyStimulus(input Vector v, input int idx);
        int rdBefore;
        int wrBefore;
        int cyc;
        logic expReads;
        logic expWrites;
        rdBefore  = readCount;
        wrBefore  = writeCount;
        expReads  = (v.expOp == 2'b01 || v.expOp == 2'b10);
        expWrites = v.we && !v.expErr;
        @(negedge clk);
        memWord    = v.memData;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.funct3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        checkOutput($sformatf("v%0d req_ready", idx), {31'b0, req_ready}, 32'h1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        checkOutput($sformatf("v%0d memOp cycle1", idx), {30'b0, memOp}, {30'b0, v.expOp});
        if (v.expOp != 2'b00)
            checkOutput($sformatf("v%0d addrB", idx), addrB, {v.addr[31:2], 2'b00});
        if (v.expOp == 2'b11)
            checkOutput($sformatf("v%0d dinB cycle1", idx), dinB, v.expWrData);
        while (!rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput($sformatf("v%0d latency", idx), 32'(cyc), 32'(v.expLat));
        checkOutput($sformatf("v%0d rdata", idx), rsp_rdata, v.expRdata);
        checkOutput($sformatf("v%0d err", idx), {31'b0, rsp_err}, {31'b0, v.expErr});
        checkOutput($sformatf("v%0d memOp at rsp", idx), {30'b0, memOp}, 32'h0);
        checkOutput($sformatf("v%0d dinB at rsp", idx), dinB, 32'h0);
        checkOutput($sformatf("v%0d reads", idx), 32'(readCount - rdBefore), {31'b0, expReads});
        checkOutput($sformatf("v%0d writes", idx), 32'(writeCount - wrBefore), {31'b0, expWrites});
        if (expWrites) begin
            checkOutput($sformatf("v%0d write addr", idx), lastWrAddr, {v.addr[31:2], 2'b00});
            checkOutput($sformatf("v%0d write data", idx), lastWrData, v.expWrData);
        end
        @(negedge clk);
        checkOutput($sformatf("v%0d rsp pulse ends", idx), {31'b0, rsp_valid}, 32'h0);
        checkOutput($sformatf("v%0d ready again", idx), {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        int wrBefore;
        int rspSeen;
        Vector tv;

        // we, funct3, addr, wdata, memData, expRdata, expErr, expOp, expLat, expWrData
        vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'b01, 3, 32'h0};
        vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h80112233, 32'hFFFFFF80, 1'b0, 2'b01, 3, 32'h0};
        vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h80112233, 32'h00000080, 1'b0, 2'b10, 3, 32'h0};
        vecs[3]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h80112233, 32'h00008011, 1'b0, 2'b10, 3, 32'h0};
        vecs[4]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'h80112233, 32'hFFFF8011, 1'b0, 2'b01, 3, 32'h0};
        vecs[5]  = '{1'b0, 3'b000, 32'h10, 32'h0,        32'h80112233, 32'h00000033, 1'b0, 2'b01, 3, 32'h0};
        vecs[6]  = '{1'b0, 3'b101, 32'h10, 32'h0,        32'h80112233, 32'h00002233, 1'b0, 2'b10, 3, 32'h0};
        vecs[7]  = '{1'b1, 3'b000, 32'h21, 32'h000000AB, 32'h11223344, 32'h0,        1'b0, 2'b10, 4, 32'h1122AB44};
        vecs[8]  = '{1'b1, 3'b001, 32'h22, 32'h0000BEEF, 32'h11223344, 32'h0,        1'b0, 2'b10, 4, 32'hBEEF3344};
        vecs[9]  = '{1'b1, 3'b000, 32'h23, 32'h55555512, 32'hAABBCCDD, 32'h0,        1'b0, 2'b10, 4, 32'h12BBCCDD};
        vecs[10] = '{1'b1, 3'b010, 32'h04, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 2'b11, 2, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 3'b001, 32'h05, 32'h0,        32'h12345678, 32'h0,        1'b1, 2'b00, 1, 32'h0};
        vecs[12] = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h12345678, 32'h0,        1'b1, 2'b00, 1, 32'h0};
        vecs[13] = '{1'b0, 3'b010, 32'h02, 32'h0,        32'h12345678, 32'h0,        1'b1, 2'b00, 1, 32'h0};
        vecs[14] = '{1'b1, 3'b011, 32'h00, 32'h1,        32'h12345678, 32'h0,        1'b1, 2'b00, 1, 32'h0};
        vecs[15] = '{1'b1, 3'b001, 32'h21, 32'h1,        32'h12345678, 32'h0,        1'b1, 2'b00, 1, 32'h0};
        vecs[16] = '{1'b0, 3'b000, 32'h11, 32'h0,        32'h80112233, 32'h00000022, 1'b0, 2'b01, 3, 32'h0};
        vecs[17] = '{1'b0, 3'b110, 32'h00, 32'h0,        32'h12345678, 32'h0,        1'b1, 2'b00, 1, 32'h0};

        reset      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        repeat (2) @(negedge clk);
        checkOutput("reset memOp", {30'b0, memOp}, 32'h0);
        checkOutput("reset addrB", addrB, 32'h0);
        checkOutput("reset dinB", dinB, 32'h0);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'h0);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'h1);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 18; i++)
            applyStimulus(vecs[i], i);

        // Spurious bValid while idle must not produce a response or memory activity.
        forceValid = 1'b1;
        rspSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) rspSeen++;
        end
        forceValid = 1'b0;
        @(negedge clk);
        checkOutput("spurious bValid rsp", 32'(rspSeen), 32'h0);
        checkOutput("spurious bValid memOp", {30'b0, memOp}, 32'h0);

        // Memory never answers: the LW must time out after 16 waiting cycles.
        stallMem = 1'b1;
        tv = '{1'b0, 3'b010, 32'h30, 32'h0, 32'hFFFFFFFF, 32'h0, 1'b1, 2'b01, 18, 32'h0};
        applyStimulus(tv, 100);

        // Reset during the read phase of an SH must abort it with no write afterwards.
        @(negedge clk);
        wrBefore   = writeCount;
        memWord    = 32'h11223344;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h22;
        req_wdata  = 32'h0000BEEF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort memOp", {30'b0, memOp}, 32'h0);
        checkOutput("abort dinB", dinB, 32'h0);
        checkOutput("abort req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("abort rsp_valid", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        reset    = 1'b1;
        stallMem = 1'b0;
        rspSeen  = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid) rspSeen++;
        end
        checkOutput("abort no write", 32'(writeCount - wrBefore), 32'h0);
        checkOutput("abort no rsp", 32'(rspSeen), 32'h0);
        checkOutput("abort idle ready", {31'b0, req_ready}, 32'h1);

        // The unit must still work normally after the aborted operation.
        applyStimulus(vecs[0], 200);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
